imem_uart_loader: RTL and testbench
===================================

# imem_uart_loader

Serial program loader for the single-cycle RISC-V core. It receives a UART byte stream from the host, assembles little-endian 32-bit words, and writes them into the instruction memory. While it loads, it holds the CPU in reset. It is the writer side of the instruction-memory interface that the core's fetch path reads, and it replaces hard-baked .coe images during bring-up.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, UART bit rate; DIV = CLK_HZ/BAUD (integer division), must be ≥ 4
- ADDR_W, 6, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- uart_rx  in  1  serial line, idle high, 8N1, LSB first; asynchronous to clk
- load_en  in  1  load-session request from a board switch; asynchronous to clk, level-sensitive
- im_we  out  1  one-cycle instruction-memory write strobe
- im_addr  out  ADDR_W  word address of the current write
- im_wdata  out  32  word being written
- cpu_hold  out  1  high while a session is active; the top-level ANDs its inverse into the CPU reset
- word_cnt  out  ADDR_W+1  number of words written in the current or last session
- load_done  out  1  one-cycle pulse when a session ends
- frame_err  out  1  sticky: a byte had a bad stop bit during this session
- ovf_err  out  1  sticky: a word arrived after MAX_WORDS words were already written
- part_err  out  1  set at session end if 1–3 bytes of an incomplete word were pending

## Operation
- Synchronization:
  - uart_rx passes through a 2-flop synchronizer, reset value 1.
  - load_en passes through a 2-flop synchronizer, reset value 0. Its synchronized value is called le_s.
- Session control:
  - Session starts on the first cycle le_s=1 while inactive. That cycle: cpu_hold←1; word_cnt, byte index, frame_err, ovf_err and part_err clear to 0.
  - Session ends on the first cycle le_s=0 while active. That cycle: cpu_hold←0, load_done pulses, and part_err←(byte index≠0). A pending partial word is discarded.
- UART RX FSM: IDLE, START, DATA, STOP, WAIT_HIGH. It runs only while the session is active; otherwise it is forced to IDLE.
  - IDLE: a synchronized 0 → START, tick counter=0.
  - START: at count DIV/2−1, sample the line. If it is 0 → DATA with bit index 0. If it is 1 → IDLE (false start, nothing recorded).
  - DATA: sample every DIV cycles, at the bit centre, shifting LSB first. After bit 7 → STOP.
  - STOP: sample after DIV cycles.
    - Sample is 1: byte accepted → IDLE.
    - Sample is 0: frame_err←1, byte discarded → WAIT_HIGH.
  - WAIT_HIGH: stay until the line reads 1 → IDLE.
- Word assembly:
  - An accepted byte k (k = byte index 0..3) is placed at bits [8k+7:8k] of the word, and the byte index increments.
  - On byte 3, the index wraps to 0 and a word is committed:
    - If word_cnt < MAX_WORDS: im_wdata←word, im_addr←word_cnt[ADDR_W-1:0], im_we pulses, and word_cnt increments.
    - Otherwise the word is dropped, ovf_err←1, and word_cnt saturates at MAX_WORDS.
- im_addr and im_wdata hold their last values between writes.

## Timing
- Reset values:
  - im_we=0, im_addr=0, im_wdata=0, cpu_hold=0, word_cnt=0, load_done=0.
  - All error flags 0. FSM in IDLE, byte index 0.
- cpu_hold latency: rises 2–3 clk after load_en rises (synchronizer plus one register stage). Falls, together with the load_done pulse, 2–3 clk after load_en falls.
- Write latency: im_we is asserted in the cycle after the accepting stop-bit sample of byte 3. It is exactly one cycle wide, and im_addr/im_wdata are valid in that same cycle.
- Per-byte time: start-bit centre + 8 data bits + stop = 9.5·DIV cycles from the falling edge of the start bit to the acceptance sample.
- Back-to-back bytes with no idle gap are supported: IDLE is re-entered before the next start edge.
- Simultaneous events:
  - Session end in the same cycle as a stop-bit acceptance: the byte is ignored and no write occurs.
  - load_en dropping mid-byte aborts the FSM to IDLE.
- Reset mid-session: all state clears immediately and cpu_hold drops asynchronously.

## Test plan
Parameters for all scenarios: CLK_HZ=16, BAUD=1 (DIV=16), ADDR_W=2.
- Basic load: with load_en=1, send bytes 13 05 A0 00 → one im_we pulse, im_addr=0, im_wdata=0x00A00513, word_cnt=1. Then drop load_en → load_done pulse, cpu_hold=0, part_err=0.
- Multiple words: send 8 bytes 01 00 00 00 02 00 00 00 back-to-back → writes 0x00000001 at addr 0, then 0x00000002 at addr 1; word_cnt=2.
- Framing error: send byte 0x55 with stop bit 0, then hold the line low for 40 cycles, release it, and send 11 22 33 44 → frame_err=1. The bad byte is discarded, and the single write is 0x44332211 at addr 0.
- Glitch and partial word:
  - A 3-cycle low pulse on uart_rx → no byte accepted.
  - Then send AA BB and drop load_en → no im_we, part_err=1, word_cnt=0.
- Overflow: send 5 words → 4 writes at addrs 0..3; the 5th is dropped; ovf_err=1, word_cnt=4.
- Reset mid-byte: assert rstn=0 during data bit 4 → all outputs go to reset values at once. After release with load_en=1 and a fresh session, the next 4 bytes write to addr 0.

Source files
------------

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART 8N1 program loader for the instruction memory.
// Assembles little-endian words and holds the CPU while loading.
// Ports:
//   clk, rstn          clock, async active-low reset
//   uart_rx, load_en   async serial line and session request
//   im_we/addr/wdata   instruction-memory write port
//   cpu_hold           high while a session is active
//   word_cnt           words written this (or last) session
//   load_done          one-cycle pulse at session end
//   frame_err/ovf_err  sticky session error flags
//   part_err           incomplete word pending at session end
module imem_uart_loader #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx,
  input  logic              load_en,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_cnt,
  output logic              load_done,
  output logic              frame_err,
  output logic              ovf_err,
  output logic              part_err
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  localparam logic [ADDR_W:0] MAX_WORDS =
    {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_e;

  // synchronizers
  logic rx_m_q;
  logic rx_s_q;
  logic le_m_q;
  logic le_s_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      le_m_q <= 1'b0;
      le_s_q <= 1'b0;
    end else begin
      rx_m_q <= uart_rx;
      rx_s_q <= rx_m_q;
      le_m_q <= load_en;
      le_s_q <= le_m_q;
    end
  end

  // receiver state
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] tick_q;
  logic [CNT_W-1:0] tick_d;
  logic [2:0]       bit_q;
  logic [2:0]       bit_d;
  logic [7:0]       sh_q;
  logic [7:0]       sh_d;

  // session / word state
  logic              active_q;
  logic              active_d;
  logic [1:0]        bidx_q;
  logic [1:0]        bidx_d;
  logic [23:0]       word_q;
  logic [23:0]       word_d;
  logic [ADDR_W:0]   wcnt_q;
  logic [ADDR_W:0]   wcnt_d;
  logic              we_q;
  logic              we_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_q;
  logic [31:0]       wdata_d;
  logic              done_q;
  logic              done_d;
  logic              fe_q;
  logic              fe_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              pe_q;
  logic              pe_d;

  logic run;
  logic byte_ok;
  logic bad_stop;

  // The receiver only advances while a session is active and
  // not ending; the end cycle itself aborts any byte.
  assign run = active_q & le_s_q;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    byte_ok  = 1'b0;
    bad_stop = 1'b0;
    if (!run) begin
      state_d = S_IDLE;
      tick_d  = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == HALF) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == LAST) begin
            tick_d = '0;
            sh_d   = {rx_s_q, sh_q[7:1]};
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == LAST) begin
            tick_d = '0;
            if (rx_s_q) begin
              byte_ok = 1'b1;
              state_d = S_IDLE;
            end else begin
              bad_stop = 1'b1;
              state_d  = S_WAIT;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    active_d = active_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    wcnt_d   = wcnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    fe_d     = fe_q;
    ovf_d    = ovf_q;
    pe_d     = pe_q;
    if (le_s_q && !active_q) begin
      active_d = 1'b1;
      wcnt_d   = '0;
      bidx_d   = '0;
      fe_d     = 1'b0;
      ovf_d    = 1'b0;
      pe_d     = 1'b0;
    end else if (!le_s_q && active_q) begin
      active_d = 1'b0;
      done_d   = 1'b1;
      pe_d     = (bidx_q != 2'd0);
      bidx_d   = '0;
    end else if (run) begin
      if (bad_stop) begin
        fe_d = 1'b1;
      end
      if (byte_ok) begin
        bidx_d = bidx_q + 2'd1;
        unique case (bidx_q)
          2'd0: word_d[7:0]   = sh_q;
          2'd1: word_d[15:8]  = sh_q;
          2'd2: word_d[23:16] = sh_q;
          2'd3: begin
            if (wcnt_q < MAX_WORDS) begin
              we_d    = 1'b1;
              addr_d  = wcnt_q[ADDR_W-1:0];
              wdata_d = {sh_q, word_q};
              wcnt_d  = wcnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      active_q <= 1'b0;
      bidx_q   <= '0;
      word_q   <= '0;
      wcnt_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      fe_q     <= 1'b0;
      ovf_q    <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      active_q <= active_d;
      bidx_q   <= bidx_d;
      word_q   <= word_d;
      wcnt_q   <= wcnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      fe_q     <= fe_d;
      ovf_q    <= ovf_d;
      pe_q     <= pe_d;
    end
  end

  assign im_we     = we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign cpu_hold  = active_q;
  assign word_cnt  = wcnt_q;
  assign load_done = done_q;
  assign frame_err = fe_q;
  assign ovf_err   = ovf_q;
  assign part_err  = pe_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: bench for the UART program loader.
// Table vectors, hand sequences and random sessions vs a model.
module tb_imem_uart_loader;

  localparam int DIV = 16;

  logic        clk;
  logic        rstn;
  logic        uart_rx;
  logic        load_en;
  logic        im_we;
  logic [1:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic [2:0]  word_cnt;
  logic        load_done;
  logic        frame_err;
  logic        ovf_err;
  logic        part_err;

  imem_uart_loader #(
    .CLK_HZ(16),
    .BAUD(1),
    .ADDR_W(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .uart_rx(uart_rx),
    .load_en(load_en),
    .im_we(im_we),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .cpu_hold(cpu_hold),
    .word_cnt(word_cnt),
    .load_done(load_done),
    .frame_err(frame_err),
    .ovf_err(ovf_err),
    .part_err(part_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // observed writes and pulses
  logic [1:0]  wr_a[$];
  logic [31:0] wr_d[$];
  int          done_cnt = 0;
  int          wide_cnt = 0;
  logic        we_prev  = 1'b0;

  always @(negedge clk) begin
    if (im_we) begin
      wr_a.push_back(im_addr);
      wr_d.push_back(im_wdata);
    end
    if (im_we && we_prev) wide_cnt++;
    we_prev = im_we;
    if (load_done) done_cnt++;
  end

  // bytes sent this session
  logic [7:0] tx_b[$];
  bit         tx_bad[$];

  typedef struct {
    string        name;
    int           n;
    logic [191:0] data;
    logic [23:0]  bad;
    bit           glitch;
    int           exp_cnt;
    bit           exp_fe;
    bit           exp_ovf;
    bit           exp_pe;
    int           exp_nw;
    logic [31:0]  exp_w0;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    if (bad) begin
      uart_rx = 1'b0;
      repeat (DIV + 40) @(negedge clk);
      uart_rx = 1'b1;
      repeat (DIV) @(negedge clk);
    end else begin
      uart_rx = 1'b1;
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic tx(input logic [7:0] b, input bit bad);
    tx_b.push_back(b);
    tx_bad.push_back(bad);
    send_byte(b, bad);
  endtask

  task automatic begin_session();
    tx_b.delete();
    tx_bad.delete();
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
    if (!load_en) begin
      load_en = 1'b1;
      @(negedge clk);
      check("hold_early", 32'(cpu_hold), 32'd0);
      repeat (2) @(negedge clk);
      check("hold_rise", 32'(cpu_hold), 32'd1);
    end else begin
      repeat (6) @(negedge clk);
      check("hold_on", 32'(cpu_hold), 32'd1);
    end
    check("cnt_clr", 32'(word_cnt), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic end_session();
    load_en = 1'b0;
    @(negedge clk);
    check("hold_late", 32'(cpu_hold), 32'd1);
    repeat (2) @(negedge clk);
    check("hold_fall", 32'(cpu_hold), 32'd0);
    check("done_hi", 32'(load_done), 32'd1);
    @(negedge clk);
    check("done_lo", 32'(load_done), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Reference: drop bad bytes, group the rest in fours, keep
  // the first four words.
  task automatic model_check(input string tag);
    logic [7:0]  g[$];
    logic [31:0] w;
    int          nw;
    int          ne;
    bit          any_bad;
    any_bad = 1'b0;
    foreach (tx_b[i]) begin
      if (tx_bad[i]) any_bad = 1'b1;
      else g.push_back(tx_b[i]);
    end
    nw = g.size() / 4;
    ne = (nw > 4) ? 4 : nw;
    check({tag, "_nwr"}, 32'(wr_d.size()), 32'(ne));
    for (int i = 0; i < ne && i < wr_d.size(); i++) begin
      w = {g[4*i+3], g[4*i+2], g[4*i+1], g[4*i]};
      check({tag, "_addr"}, 32'(wr_a[i]), 32'(i));
      check({tag, "_data"}, wr_d[i], w);
    end
    check({tag, "_cnt"}, 32'(word_cnt), 32'(ne));
    check({tag, "_fe"}, 32'(frame_err), 32'(any_bad));
    check({tag, "_ovf"}, 32'(ovf_err), 32'(nw > 4));
    check({tag, "_pe"}, 32'(part_err), 32'((g.size() % 4) != 0));
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    begin_session();
    if (v.glitch) begin
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
    end
    for (int i = 0; i < v.n; i++) begin
      tx(v.data[191-8*i -: 8], v.bad[i]);
    end
    repeat (4) @(negedge clk);
    end_session();
    check({v.name, "_cnt"}, 32'(word_cnt), 32'(v.exp_cnt));
    check({v.name, "_fe"}, 32'(frame_err), 32'(v.exp_fe));
    check({v.name, "_ovf"}, 32'(ovf_err), 32'(v.exp_ovf));
    check({v.name, "_pe"}, 32'(part_err), 32'(v.exp_pe));
    check({v.name, "_nw"}, 32'(wr_d.size()), 32'(v.exp_nw));
    if (v.exp_nw > 0 && wr_d.size() > 0) begin
      check({v.name, "_a0"}, 32'(wr_a[0]), 32'd0);
      check({v.name, "_w0"}, wr_d[0], v.exp_w0);
    end
    model_check(v.name);
  endtask

  initial begin
    logic [7:0] pb;
    int         n;
    int         gap;

    vt[0] = '{"basic", 4, {32'h1305A000, 160'h0}, 24'h0,
              1'b0, 1, 1'b0, 1'b0, 1'b0, 1, 32'h00A00513};
    vt[1] = '{"multi", 8, {64'h01000000_02000000, 128'h0},
              24'h0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 2, 32'h1};
    vt[2] = '{"frame", 5, {40'h55_11223344, 152'h0},
              24'h000001, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1,
              32'h44332211};
    vt[3] = '{"glitch", 2, {16'hAABB, 176'h0}, 24'h0,
              1'b1, 0, 1'b0, 1'b0, 1'b1, 0, 32'h0};
    vt[4] = '{"ovf", 20,
              {160'h01000000_02000000_03000000_04000000_05000000,
               32'h0},
              24'h0, 1'b0, 4, 1'b0, 1'b1, 1'b0, 4, 32'h1};

    rstn    = 1'b0;
    uart_rx = 1'b1;
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(im_we), 32'd0);
    check("rst_addr", 32'(im_addr), 32'd0);
    check("rst_wdata", im_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_errs", 32'({frame_err, ovf_err, part_err}), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vt[i]) run_vec(vt[i]);

    // load_en dropped mid-byte after three bytes
    begin_session();
    tx(8'h11, 1'b0);
    tx(8'h22, 1'b0);
    tx(8'h33, 1'b0);
    pb = 8'hC3;
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = pb[i];
      repeat (DIV) @(negedge clk);
    end
    end_session();
    uart_rx = 1'b1;
    model_check("abort");
    check("abort_pe", 32'(part_err), 32'd1);
    begin_session();
    tx(8'h0D, 1'b0);
    tx(8'hF0, 1'b0);
    tx(8'h0D, 1'b0);
    tx(8'hF0, 1'b0);
    repeat (4) @(negedge clk);
    end_session();
    model_check("after_abort");

    // reset during data bit 4
    begin_session();
    tx(8'hEF, 1'b0);
    tx(8'hBE, 1'b0);
    tx(8'hAD, 1'b0);
    tx(8'hDE, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_cnt", 32'(word_cnt), 32'd1);
    check("pre_rst_wd", im_wdata, 32'hDEADBEEF);
    pb = 8'h5A;
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = pb[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = pb[4];
    repeat (DIV / 2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_hold", 32'(cpu_hold), 32'd0);
    check("mid_rst_cnt", 32'(word_cnt), 32'd0);
    check("mid_rst_wd", im_wdata, 32'd0);
    check("mid_rst_we", 32'(im_we), 32'd0);
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    begin_session();
    tx(8'h78, 1'b0);
    tx(8'h56, 1'b0);
    tx(8'h34, 1'b0);
    tx(8'h12, 1'b0);
    repeat (4) @(negedge clk);
    end_session();
    model_check("post_rst");
    if (wr_d.size() > 0) begin
      check("post_rst_a0", 32'(wr_a[0]), 32'd0);
      check("post_rst_w0", wr_d[0], 32'h12345678);
    end else begin
      check("post_rst_nw", 32'(wr_d.size()), 32'd1);
    end

    // random sessions
    for (int s = 0; s < 6; s++) begin
      begin_session();
      n = $urandom_range(0, 22);
      for (int i = 0; i < n; i++) begin
        tx(8'($urandom), $urandom_range(0, 7) == 0);
        gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 20);
        repeat (gap) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      end_session();
      model_check("rand");
    end

    check("we_width", 32'(wide_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
